led_pattern_gen: RTL and testbench

Parametrised multi-channel LED pattern generator: a shared prescaler drives CHANNELS independent pattern engines, each runtime-configurable as OFF, ON, PWM or BREATHE. It replaces the fixed single-counter blinker and sits after the PLL clock (`clk0` domain) and user reset in the top level. One LED per channel is driven from a registered output.

---
 rtl/led_pattern_pkg.sv | 10 +
 rtl/led_pattern_chan.sv | 60 ++++++
 rtl/led_pattern_gen.sv | 51 +++++
 tb/tb_led_pattern_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encodings shared by the LED pattern generator and its channels
package led_pattern_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;
endpackage

// File: rtl/led_pattern_chan.sv
// led_pattern_chan: one LED channel with config, phase, breathing ramp and registered output
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              sync,
  input  logic              we,
  input  logic [MODE_W-1:0] mode,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  duty,
  output logic              led
);
  mode_e             mode_q;
  logic [CNT_W-1:0]  period_q, duty_q, phase, ramp, ramp_step;
  logic              down, down_nxt, wrap, led_nxt;
  // a zero period has no room to ramp, so the ramp holds at 0
  always_comb begin
    wrap      = phase == period_q;
    ramp_step = (period_q == '0) ? ramp : down ? ramp - CNT_W'(1) : ramp + CNT_W'(1);
    down_nxt  = (period_q == '0) ? down : down ? (ramp_step != '0) : (ramp_step == period_q);
    led_nxt   = (mode_q == MODE_ON)      ? 1'b1 :
                (mode_q == MODE_PWM)     ? (phase < duty_q) :
                (mode_q == MODE_BREATHE) ? (phase < ramp) : 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_OFF;
      period_q <= '0;
      duty_q   <= '0;
      phase    <= '0;
      ramp     <= '0;
      down     <= 1'b0;
      led      <= 1'b0;
    end else begin
      if (we) begin
        mode_q   <= mode_e'(mode);
        period_q <= period;
        duty_q   <= duty;
        phase    <= '0;
        ramp     <= '0;
        down     <= 1'b0;
      end else if (sync) begin
        phase <= '0;
        ramp  <= '0;
        down  <= 1'b0;
      end else if (tick) begin
        phase <= wrap ? '0 : phase + CNT_W'(1);
        if (wrap) begin
          ramp <= ramp_step;
          down <= down_nxt;
        end
      end
      led <= led_nxt;
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: shared tick prescaler feeding CHANNELS independent LED pattern engines
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int PRESCALE_DIV = 1000000,
  parameter int PRESCALE_W   = 20,
  parameter int CNT_W        = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_we,
  input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] cfg_ch,
  input  logic [MODE_W-1:0]                             cfg_mode,
  input  logic [CNT_W-1:0]                              cfg_period,
  input  logic [CNT_W-1:0]                              cfg_duty,
  input  logic                                          sync,
  output logic                                          tick,
  output logic [CHANNELS-1:0]                           led
);
  localparam int CH_W = $clog2(CHANNELS > 1 ? CHANNELS : 2);
  logic [PRESCALE_W-1:0] pre;
  logic                  pre_end, itick;
  always_comb begin
    pre_end = pre == PRESCALE_W'(PRESCALE_DIV - 1);
    itick   = pre_end && !sync;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= (sync || pre_end) ? '0 : pre + PRESCALE_W'(1);
      tick <= itick;
    end
  end
  // channel indices >= CHANNELS match no instance, so such writes are dropped
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_pattern_chan #(.CNT_W(CNT_W)) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (itick),
      .sync  (sync),
      .we    (cfg_we && cfg_ch == CH_W'(i)),
      .mode  (cfg_mode),
      .period(cfg_period),
      .duty  (cfg_duty),
      .led   (led[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench on a 4-channel DIV=4 build and a 3-channel DIV=1 build
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_we, a_sync, a_tick;
  logic [1:0] a_ch, a_mode;
  logic [7:0] a_per, a_duty;
  logic [3:0] a_led;
  logic       b_we, b_sync, b_tick;
  logic [1:0] b_ch, b_mode;
  logic [7:0] b_per, b_duty;
  logic [2:0] b_led;
  int         checks = 0;
  int         fails = 0;
  logic [7:0] sb[$];
  logic [7:0] e;

  always #5 clk = ~clk;

  led_pattern_gen #(.CHANNELS(4), .PRESCALE_DIV(4), .PRESCALE_W(20), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .cfg_we(a_we), .cfg_ch(a_ch), .cfg_mode(a_mode),
    .cfg_period(a_per), .cfg_duty(a_duty), .sync(a_sync), .tick(a_tick), .led(a_led)
  );
  led_pattern_gen #(.CHANNELS(3), .PRESCALE_DIV(1), .PRESCALE_W(20), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_mode(b_mode),
    .cfg_period(b_per), .cfg_duty(b_duty), .sync(b_sync), .tick(b_tick), .led(b_led)
  );

  function automatic bit pwm(int t, int p, int d);
    return (t % (p + 1)) < d;
  endfunction

  // triangle ramp 0..p..0 stepping once per completed cycle
  function automatic bit bre(int t, int p);
    int c, m, r;
    if (p == 0) return 1'b0;
    c = t / (p + 1);
    m = c % (2 * p);
    r = (m <= p) ? m : 2 * p - m;
    return (t % (p + 1)) < r;
  endfunction

  task automatic wr(input bit sel, input logic [1:0] ch, input logic [1:0] mode,
                    input logic [7:0] per, input logic [7:0] duty);
    if (sel) begin
      b_we = 1'b1; b_ch = ch; b_mode = mode; b_per = per; b_duty = duty;
    end else begin
      a_we = 1'b1; a_ch = ch; a_mode = mode; a_per = per; a_duty = duty;
    end
    @(negedge clk);
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b_tick, b_led, a_tick, a_led} !== 9'b0) begin
      fails++;
      $display("FAIL reset_state got %b required 000000000", {b_tick, b_led, a_tick, a_led});
    end
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back({2'b00, 1'b1, (k % 4 == 0), 4'b0000});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({b_tick, a_tick, a_led} !== e[5:0]) begin
        fails++;
        $display("FAIL reset_tick k=%0d got %b required %b", k, {b_tick, a_tick, a_led}, e[5:0]);
      end
    end
  endtask

  task automatic test_pwm;
    int duties[3] = '{1, 0, 5};
    for (int d = 0; d < 3; d++) begin
      wr(1'b1, 2'd0, 2'd2, 8'd3, 8'(duties[d]));
      for (int k = 0; k < 12; k++) begin
        sb.push_back({7'b0, pwm(k, 3, duties[d])});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (b_led[0] !== e[0]) begin
          fails++;
          $display("FAIL pwm duty=%0d k=%0d got %b required %b", duties[d], k, b_led[0], e[0]);
        end
      end
    end
  endtask

  task automatic test_breathe;
    wr(1'b1, 2'd1, 2'd3, 8'd2, 8'd7);
    for (int k = 0; k < 24; k++) begin
      if (k == 10) begin
        b_we = 1'b1; b_ch = 2'd3; b_mode = 2'd1; b_per = 8'd0; b_duty = 8'd0;
      end else b_we = 1'b0;
      sb.push_back({5'b0, 1'b0, bre(k, 2), 1'b1});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (b_led !== e[2:0]) begin
        fails++;
        $display("FAIL breathe k=%0d got %b required %b", k, b_led, e[2:0]);
      end
    end
    b_we = 1'b0;
  endtask

  task automatic test_on_off;
    wr(1'b0, 2'd2, 2'd1, 8'd0, 8'd0);
    wr(1'b0, 2'd3, 2'd0, 8'd0, 8'd0);
    wr(1'b0, 2'd0, 2'd2, 8'd3, 8'd2);
    wr(1'b0, 2'd1, 2'd3, 8'd1, 8'd0);
    sb.push_back(8'b01);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (a_led[3:2] !== e[1:0]) begin
      fails++;
      $display("FAIL on_off got %b required %b", a_led[3:2], e[1:0]);
    end
  endtask

  task automatic test_sync;
    int n = 0;
    int t;
    while (a_tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (a_tick !== 1'b1) begin
      fails++;
      $display("FAIL sync_wait_tick got %b required 1", a_tick);
    end
    repeat (3) @(negedge clk);
    a_sync = 1'b1;
    a_we = 1'b1; a_ch = 2'd0; a_mode = 2'd2; a_per = 8'd3; a_duty = 8'd1;
    @(negedge clk);
    a_sync = 1'b0;
    a_we = 1'b0;
    checks++;
    if (a_tick !== 1'b0) begin
      fails++;
      $display("FAIL sync_tick_suppressed got %b required 0", a_tick);
    end
    for (int j = 1; j <= 20; j++) begin
      t = (j - 1) / 4;
      sb.push_back({3'b0, (j % 4 == 0), 1'b0, 1'b1, bre(t, 1), pwm(t, 3, 1)});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({a_tick, a_led} !== e[4:0]) begin
        fails++;
        $display("FAIL sync j=%0d got %b required %b", j, {a_tick, a_led}, e[4:0]);
      end
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({a_tick, a_led, b_led} !== 8'b0) begin
      fails++;
      $display("FAIL async_reset got %b required 00000000", {a_tick, a_led, b_led});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sb.push_back({3'b0, (k % 4 == 0), 4'b0000});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({a_tick, a_led} !== e[4:0]) begin
        fails++;
        $display("FAIL after_reset k=%0d got %b required %b", k, {a_tick, a_led}, e[4:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    a_we = 1'b0; a_sync = 1'b0; a_ch = '0; a_mode = '0; a_per = '0; a_duty = '0;
    b_we = 1'b0; b_sync = 1'b0; b_ch = '0; b_mode = '0; b_per = '0; b_duty = '0;
    test_reset();
    test_pwm();
    test_breathe();
    test_on_off();
    test_sync();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
